// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the RV32I 5-stage pipeline.
// Used by the fetch stage and reused by decode (if_id_t).
package pipe_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      FLUSH = 2'd3
   } fe_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pcplus4;
      logic [XLEN-1:0] ir;
      logic            valid;
   } if_id_t;

   // Redirect targets are word addresses; the low two bits are dropped.
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: hold, redirect-load or +4 increment.
// Redirect load has priority over the increment.
module pc_reg
   import pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            load_i,
   input  logic [XLEN-1:0] load_pc_i,
   input  logic            advance_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o
);

   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] pc_plus4;

   // Plain 32-bit add: 32'hFFFF_FFFC + 4 wraps to 0.
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      pc_d = pc_q;
      if (load_i) begin
         pc_d = align_word(load_pc_i);
      end else if (advance_i) begin
         pc_d = pc_plus4;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: owns the PC, honours load-use stalls and EX redirects.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [XLEN-1:0] NOP_INSN = pipe_pkg::NOP_INSN
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            pc_write,
   input  logic            if_id_write,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] if_id_pc,
   output logic [XLEN-1:0] if_id_pcplus4,
   output logic [XLEN-1:0] if_id_ir,
   output logic            if_id_valid,
   output logic [1:0]      fe_state
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [XLEN-1:0] cnt_fetch,
   output logic [XLEN-1:0] cnt_stall,
   output logic [XLEN-1:0] cnt_flush
`endif
);

   fe_state_t       state_q;
   if_id_t          if_id_q;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_plus4;
   logic            active;
   logic            take_redirect;
   logic            pc_advance;
   logic            if_id_load;

   // Outside BOOT every input is live; a redirect overrides both stall requests.
   assign active        = (state_q != BOOT);
   assign take_redirect = active && redirect_valid;
   assign pc_advance    = active && !redirect_valid && pc_write;
   assign if_id_load    = active && !redirect_valid && if_id_write;

   pc_reg #(
      .RESET_PC (RESET_PC)
   ) u_pc_reg (
      .clk        (clk),
      .rstn       (rstn),
      .load_i     (take_redirect),
      .load_pc_i  (redirect_pc),
      .advance_i  (pc_advance),
      .pc_o       (pc),
      .pc_plus4_o (pc_plus4)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= BOOT;
         if_id_q <= '{pc: '0, pcplus4: 32'd4, ir: NOP_INSN, valid: 1'b0};
      end else begin
         case (state_q)
            BOOT: begin
               state_q <= RUN;
            end
            default: begin
               if (redirect_valid) begin
                  // The instruction fetched this cycle is on the wrong path.
                  if_id_q <= '{pc: pc, pcplus4: pc_plus4, ir: NOP_INSN, valid: 1'b0};
                  state_q <= FLUSH;
               end else begin
                  if (if_id_write) begin
                     if_id_q <= '{pc: pc, pcplus4: pc_plus4, ir: imem_rdata, valid: 1'b1};
                  end
                  state_q <= (!pc_write || !if_id_write) ? STALL : RUN;
               end
            end
         endcase
      end
   end

   assign imem_addr     = pc;
   assign if_id_pc      = if_id_q.pc;
   assign if_id_pcplus4 = if_id_q.pcplus4;
   assign if_id_ir      = if_id_q.ir;
   assign if_id_valid   = if_id_q.valid;
   assign fe_state      = state_q;

`ifdef FETCH_PERF_CNT_EN
   logic [XLEN-1:0] cnt_fetch_q;
   logic [XLEN-1:0] cnt_stall_q;
   logic [XLEN-1:0] cnt_flush_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         cnt_fetch_q <= '0;
         cnt_stall_q <= '0;
         cnt_flush_q <= '0;
      end else begin
         if (if_id_load) begin
            cnt_fetch_q <= cnt_fetch_q + 32'd1;
         end
         if (active && !redirect_valid && !pc_write) begin
            cnt_stall_q <= cnt_stall_q + 32'd1;
         end
         if (take_redirect) begin
            cnt_flush_q <= cnt_flush_q + 32'd1;
         end
      end
   end

   assign cnt_fetch = cnt_fetch_q;
   assign cnt_stall = cnt_stall_q;
   assign cnt_flush = cnt_flush_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID snapshots,
// a monitor pops and compares them against the DUT outputs.
module tb_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [1:0]  S_BOOT  = 2'd0;
   localparam logic [1:0]  S_RUN   = 2'd1;
   localparam logic [1:0]  S_STALL = 2'd2;
   localparam logic [1:0]  S_FLUSH = 2'd3;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] pc;
      logic [31:0] pcp4;
      logic [31:0] ir;
      logic        valid;
      logic [1:0]  state;
   } exp_t;

   logic        clk;
   logic        rstn;
   logic        pc_write;
   logic        if_id_write;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] if_id_pc;
   logic [31:0] if_id_pcplus4;
   logic [31:0] if_id_ir;
   logic        if_id_valid;
   logic [1:0]  fe_state;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] cnt_fetch;
   logic [31:0] cnt_stall;
   logic [31:0] cnt_flush;
`endif

   exp_t exp_q[$];
   int   n_checks;
   int   n_errors;
   event mid_ev;

   fetch_stage dut (
      .clk            (clk),
      .rstn           (rstn),
      .pc_write       (pc_write),
      .if_id_write    (if_id_write),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .if_id_pc       (if_id_pc),
      .if_id_pcplus4  (if_id_pcplus4),
      .if_id_ir       (if_id_ir),
      .if_id_valid    (if_id_valid),
      .fe_state       (fe_state)
`ifdef FETCH_PERF_CNT_EN
      ,
      .cnt_fetch      (cnt_fetch),
      .cnt_stall      (cnt_stall),
      .cnt_flush      (cnt_flush)
`endif
   );

   // Instruction memory model: word 0 is addi x1,x0,5; others are address-tagged.
   function automatic logic [31:0] mem(input logic [31:0] a);
      return 32'h0050_0093 + (a << 12);
   endfunction

   assign imem_rdata = mem(imem_addr);

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk or mid_ev);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("imem_addr",     imem_addr,             e.addr);
            chk("if_id_pc",      if_id_pc,              e.pc);
            chk("if_id_pcplus4", if_id_pcplus4,         e.pcp4);
            chk("if_id_ir",      if_id_ir,              e.ir);
            chk("if_id_valid",   {31'd0, if_id_valid},  {31'd0, e.valid});
            chk("fe_state",      {30'd0, fe_state},     {30'd0, e.state});
         end
      end
   end

   task automatic push_exp(input logic [31:0] addr, input logic [31:0] pc, input logic [31:0] pcp4,
                           input logic [31:0] ir, input logic valid, input logic [1:0] st);
      exp_t e;
      e = '{addr: addr, pc: pc, pcp4: pcp4, ir: ir, valid: valid, state: st};
      exp_q.push_back(e);
   endtask

   task automatic push_reset_exp();
      push_exp(32'h0, 32'h0, 32'h4, NOP, 1'b0, S_BOOT);
   endtask

   // driver: hold inputs for one cycle, then expect the post-edge outputs
   task automatic cyc(input logic pw, input logic iw, input logic rv, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic [31:0] e_pc,
                      input logic [31:0] e_ir, input logic e_valid, input logic [1:0] e_st);
      pc_write       = pw;
      if_id_write    = iw;
      redirect_valid = rv;
      redirect_pc    = rpc;
      @(posedge clk);
      #1;
      push_exp(e_addr, e_pc, e_pc + 32'd4, e_ir, e_valid, e_st);
   endtask

   initial begin
      rstn           = 1'b0;
      pc_write       = 1'b1;
      if_id_write    = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      n_checks       = 0;
      n_errors       = 0;
      push_reset_exp();
      @(negedge clk);
      #2;
      rstn = 1'b1;

      // boot, then sequential fetch
      cyc(1, 1, 0, 32'h0,        32'h0,   32'h0,   NOP,           0, S_RUN);
      cyc(1, 1, 0, 32'h0,        32'h4,   32'h0,   32'h0050_0093, 1, S_RUN);
      cyc(1, 1, 0, 32'h0,        32'h8,   32'h4,   mem(32'h4),    1, S_RUN);
      // load-use stall at pc 8
      cyc(0, 0, 0, 32'h0,        32'h8,   32'h4,   mem(32'h4),    1, S_STALL);
      cyc(1, 1, 0, 32'h0,        32'hC,   32'h8,   mem(32'h8),    1, S_RUN);
      cyc(1, 1, 0, 32'h0,        32'h10,  32'hC,   mem(32'hC),    1, S_RUN);
      // redirect at pc 16 to an unaligned target
      cyc(1, 1, 1, 32'h103,      32'h100, 32'h10,  NOP,           0, S_FLUSH);
      cyc(1, 1, 0, 32'h0,        32'h104, 32'h100, mem(32'h100),  1, S_RUN);
      // redirect beats a simultaneous stall
      cyc(0, 0, 1, 32'h40,       32'h40,  32'h104, NOP,           0, S_FLUSH);
      // second redirect while in FLUSH
      cyc(1, 1, 1, 32'h200,      32'h200, 32'h40,  NOP,           0, S_FLUSH);
      cyc(1, 1, 0, 32'h0,        32'h204, 32'h200, mem(32'h200),  1, S_RUN);
      // split stall controls
      cyc(1, 0, 0, 32'h0,        32'h208, 32'h200, mem(32'h200),  1, S_STALL);
      cyc(1, 1, 0, 32'h0,        32'h20C, 32'h208, mem(32'h208),  1, S_RUN);
      cyc(0, 1, 0, 32'h0,        32'h20C, 32'h20C, mem(32'h20C),  1, S_STALL);
      cyc(1, 1, 0, 32'h0,        32'h210, 32'h20C, mem(32'h20C),  1, S_RUN);
      // wrap at the top of the address space
      cyc(1, 1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 32'h210, NOP,    0, S_FLUSH);
      cyc(1, 1, 0, 32'h0,        32'h0,   32'hFFFF_FFFC, mem(32'hFFFF_FFFC), 1, S_RUN);
      cyc(1, 1, 0, 32'h0,        32'h4,   32'h0,   32'h0050_0093, 1, S_RUN);
      cyc(0, 0, 0, 32'h0,        32'h4,   32'h0,   32'h0050_0093, 1, S_STALL);

      // asynchronous reset in the middle of a stall, checked before any clock edge
      @(negedge clk);
      #2;
      rstn = 1'b0;
      #1;
      push_reset_exp();
      -> mid_ev;
      @(posedge clk);
      #1;
      push_reset_exp();
      @(negedge clk);
      #2;
      rstn = 1'b1;

      // BOOT ignores a redirect and stall request
      cyc(0, 0, 1, 32'h80,       32'h0,   32'h0,   NOP,           0, S_RUN);
      cyc(1, 1, 0, 32'h0,        32'h4,   32'h0,   32'h0050_0093, 1, S_RUN);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (exp_q.size() > 0) begin
         n_errors++;
         $display("FAIL drain: %0d expected entries never compared, required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
